mips_mc_ctrl: RTL
=================

// Module: mips_mc_ctrl
// PURPOSE
//  Multi-cycle control unit driving the mips_dp control inputs (RegDst, RegWr, ExtOp, nPC_sel,
//  ALUctr, MemtoReg, MemWr, ALUSrc, j_sel) from the Instruction word and ALU zero flag it returns.
//  Sequences each instruction through IF/ID/EXE/MEM/WB; strobes state-changing writes once per instr.
//  Supports addu, subu, ori, lui, lw, sw, beq, j. Adds pc_wr/ir_wr and a retired-instruction counter.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter instr_cnt (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  Instruction  in   32     current instruction word from datapath
//  zero         in   1      ALU zero flag (datapath zero bit 0)
//  RegDst       out  1      1 = rd [15:11], 0 = rt [20:16]
//  RegWr        out  1      register-file write strobe
//  ExtOp        out  2      00 zero-ext, 01 sign-ext, 10 imm<<16 (lui)
//  nPC_sel      out  2      00 pc+4, 01 branch target, 10 jump
//  ALUctr       out  2      00 add, 01 sub, 10 or
//  MemtoReg     out  1      1 = busW from Data_out
//  MemWr        out  1      data-memory write strobe
//  ALUSrc       out  1      1 = imm32 to ALU B
//  j_sel        out  1      select jump target value
//  pc_wr        out  1      PC update strobe (one cycle, last state of instr)
//  ir_wr        out  1      instruction-register load strobe
//  instr_cnt    out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  - Reset: state=IF, latched op/funct=0, instr_cnt=0; all outputs 0 except ir_wr=1 (IF is Moore).
//  - States: IF->ID always. ID: latch Instruction[31:26],[5:0]; j->IF (pc_wr, nPC_sel=10, j_sel=1);
//    else EXE. EXE: beq->IF (ALUctr=01, ALUSrc=0, pc_wr, nPC_sel=zero?01:00); lw/sw->MEM; R/ori/lui->WB.
//    MEM: sw->IF (MemWr, pc_wr); lw->WB. WB: RegWr, pc_wr ->IF.
//  - Latency (cycles): j 2, beq 3, sw 4, R-type/ori/lui 4, lw 5.
//  - Outputs are a function of registered state + latched op/funct only (Moore); zero sampled
//    combinationally in EXE for beq only.
//  - RegWr, MemWr, pc_wr each high exactly one cycle per instr; never two in same cycle except pc_wr
//    with RegWr (WB) or with MemWr (sw MEM). nPC_sel=00, j_sel=0 whenever pc_wr=0.
//  - Datapath controls held stable from EXE through WB of an instruction (ALUctr, ALUSrc, ExtOp,
//    RegDst, MemtoReg).
//  - Encodings: addu 000000/100001: ALUctr 00, RegDst 1; subu funct 100011: ALUctr 01, RegDst 1;
//    ori 001101: ALUctr 10, ExtOp 00, ALUSrc 1; lui 001111: ALUctr 10, ExtOp 10, ALUSrc 1 (rs=$0);
//    lw 100011 / sw 101011: ALUctr 00, ExtOp 01, ALUSrc 1, lw MemtoReg 1; beq 000100: ExtOp 01.
//  - instr_cnt increments on every pc_wr cycle; wraps all-ones -> 0.
//  - rst asserted mid-instruction: immediate return to IF, no pending write strobe issued.
// CONFIGURATION
//  MIPS_CTRL_TRAP_EN defined: unsupported op/funct in ID -> HALT state; output illegal (1 bit, extra
//    port) held 1, all strobes 0, stays until rst; instr_cnt frozen.
//  Not defined: unsupported op/funct treated as NOP: ID->IF with pc_wr, nPC_sel=00; counts as retired.
// STRUCTURE
//  mips_pkg: opcode/funct localparams, state encoding, ALUctr/ExtOp/nPC_sel encodings.
//  Sub-module mips_ctrl_dec: combinational op/funct -> instruction class (R_ADDU,R_SUBU,ORI,LUI,LW,
//    SW,BEQ,J,ILL); FSM and counter stay in mips_mc_ctrl.
// TESTING
//  1 rst pulse mid-EXE of lw -> next cycle state IF, ir_wr=1, RegWr/MemWr/pc_wr=0, instr_cnt=0.
//  2 addu 0x00221821 -> RegWr+pc_wr in cycle 4 only, RegDst=1, ALUctr=00; instr_cnt 0->1.
//  3 lw 0x8C430004 then sw 0xAC430008 -> lw MemtoReg=1 RegWr cycle 5; sw MemWr cycle 4; cnt=2.
//  4 beq 0x10220003 with zero=1 -> cycle 3 nPC_sel=01; zero=0 -> nPC_sel=00; pc_wr both.
//  5 j 0x08000010 -> cycle 2 pc_wr=1, nPC_sel=10, j_sel=1; lui 0x3C011234 -> ExtOp=10, ALUSrc=1.
//  6 op 0x3F: TRAP_EN -> illegal=1 held, no strobes for 10 cycles; else NOP, cycle 2 pc_wr, cnt+1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs, FSM states,
// instruction classes and datapath select codes.
package mips_pkg;

  localparam int unsigned OP_W = 6;
  localparam int unsigned FN_W = 6;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;

  localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OR  = 2'b10;

  localparam logic [SEL_W-1:0] EXT_ZERO = 2'b00;
  localparam logic [SEL_W-1:0] EXT_SIGN = 2'b01;
  localparam logic [SEL_W-1:0] EXT_LUI  = 2'b10;

  localparam logic [SEL_W-1:0] NPC_SEQ = 2'b00;
  localparam logic [SEL_W-1:0] NPC_BR  = 2'b01;
  localparam logic [SEL_W-1:0] NPC_J   = 2'b10;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU = 4'd0,
    C_SUBU = 4'd1,
    C_ORI  = 4'd2,
    C_LUI  = 4'd3,
    C_LW   = 4'd4,
    C_SW   = 4'd5,
    C_BEQ  = 4'd6,
    C_J    = 4'd7,
    C_ILL  = 4'd8
  } iclass_t;

endpackage

// File: rtl/mips_ctrl_dec.sv
// Combinational opcode/funct decoder producing the instruction class.
module mips_ctrl_dec
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [FN_W-1:0] funct,
  output iclass_t         iclass_c
);

  always_comb begin
    iclass_c = C_ILL;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      iclass_c = C_ADDU;
        else if (funct == FN_SUBU) iclass_c = C_SUBU;
      end
      OP_ORI:  iclass_c = C_ORI;
      OP_LUI:  iclass_c = C_LUI;
      OP_LW:   iclass_c = C_LW;
      OP_SW:   iclass_c = C_SW;
      OP_BEQ:  iclass_c = C_BEQ;
      OP_J:    iclass_c = C_J;
      default: iclass_c = C_ILL;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB control unit with retired-instruction counter.
// Optional MIPS_CTRL_TRAP_EN: illegal instructions halt the unit and raise 'illegal'.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instruction,
  input  logic             zero,
  output logic             RegDst,
  output logic             RegWr,
  output logic [1:0]       ExtOp,
  output logic [1:0]       nPC_sel,
  output logic [1:0]       ALUctr,
  output logic             MemtoReg,
  output logic             MemWr,
  output logic             ALUSrc,
  output logic             j_sel,
  output logic             pc_wr,
  output logic             ir_wr,
`ifdef MIPS_CTRL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] instr_cnt
);

  state_t          state, state_nxt;
  logic [OP_W-1:0] op_q;
  logic [FN_W-1:0] funct_q;
  logic [OP_W-1:0] dec_op;
  logic [FN_W-1:0] dec_funct;
  iclass_t         iclass;
  logic            dp_active;
  logic            unused_bits;

  assign unused_bits = ^Instruction[25:6];

  // In ID the IR is fresh but not yet latched, so decode it directly.
  assign dec_op    = (state == S_ID) ? Instruction[31:26] : op_q;
  assign dec_funct = (state == S_ID) ? Instruction[5:0]   : funct_q;
  assign dp_active = (state == S_EXE) || (state == S_MEM) || (state == S_WB);

  mips_ctrl_dec u_dec (
    .op       (dec_op),
    .funct    (dec_funct),
    .iclass_c (iclass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IF;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ID) begin
        op_q    <= Instruction[31:26];
        funct_q <= Instruction[5:0];
      end
    end
  end

  // Every instruction retires on its single pc_wr cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        instr_cnt <= '0;
    else if (pc_wr) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    RegDst    = 1'b0;
    RegWr     = 1'b0;
    ExtOp     = EXT_ZERO;
    nPC_sel   = NPC_SEQ;
    ALUctr    = ALU_ADD;
    MemtoReg  = 1'b0;
    MemWr     = 1'b0;
    ALUSrc    = 1'b0;
    j_sel     = 1'b0;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
`ifdef MIPS_CTRL_TRAP_EN
    illegal   = 1'b0;
`endif

    // Datapath selects held constant across EXE..WB of the latched instruction.
    if (dp_active) begin
      case (iclass)
        C_ADDU: RegDst = 1'b1;
        C_SUBU: begin
          RegDst = 1'b1;
          ALUctr = ALU_SUB;
        end
        C_ORI: begin
          ALUctr = ALU_OR;
          ALUSrc = 1'b1;
        end
        C_LUI: begin
          ALUctr = ALU_OR;
          ExtOp  = EXT_LUI;
          ALUSrc = 1'b1;
        end
        C_LW: begin
          ExtOp    = EXT_SIGN;
          ALUSrc   = 1'b1;
          MemtoReg = 1'b1;
        end
        C_SW: begin
          ExtOp  = EXT_SIGN;
          ALUSrc = 1'b1;
        end
        C_BEQ: begin
          ALUctr = ALU_SUB;
          ExtOp  = EXT_SIGN;
        end
        default: ;
      endcase
    end

    case (state)
      S_IF: begin
        ir_wr     = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: begin
        case (iclass)
          C_J: begin
            pc_wr     = 1'b1;
            nPC_sel   = NPC_J;
            j_sel     = 1'b1;
            state_nxt = S_IF;
          end
          C_ILL: begin
`ifdef MIPS_CTRL_TRAP_EN
            state_nxt = S_HALT;
`else
            pc_wr     = 1'b1;
            state_nxt = S_IF;
`endif
          end
          default: state_nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        case (iclass)
          C_BEQ: begin
            pc_wr     = 1'b1;
            nPC_sel   = zero ? NPC_BR : NPC_SEQ;
            state_nxt = S_IF;
          end
          C_LW, C_SW: state_nxt = S_MEM;
          default:    state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (iclass == C_SW) begin
          MemWr     = 1'b1;
          pc_wr     = 1'b1;
          state_nxt = S_IF;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        RegWr     = 1'b1;
        pc_wr     = 1'b1;
        state_nxt = S_IF;
      end
      S_HALT: begin
`ifdef MIPS_CTRL_TRAP_EN
        illegal   = 1'b1;
        state_nxt = S_HALT;
`else
        state_nxt = S_IF;
`endif
      end
      default: state_nxt = S_IF;
    endcase
  end

endmodule
